// File: rtl/eth_axis_tx_arbiter_if.sv
// eth_axis_tx_arbiter_if
// AXI-stream bundle used on both sides of the TX arbiter. N lanes share one
// bundle: lane i owns tdata/tkeep slice i and bit i of tvalid/tready/tlast/tuser.
//   tdata  [N*DATA_WIDTH] - per-lane data
//   tkeep  [N*KEEP_WIDTH] - per-lane byte enables
//   tvalid/tready/tlast/tuser [N] - per-lane handshake, end-of-frame, bad-frame flag
//   tid    [ID_WIDTH]     - source index of the beat (meaningful on the merged side)
// master drives the payload and reads tready; slave is the mirror view.
interface eth_axis_tx_arbiter_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic [N*DATA_WIDTH-1:0] tdata;
  logic [N*KEEP_WIDTH-1:0] tkeep;
  logic [N-1:0]            tvalid;
  logic [N-1:0]            tready;
  logic [N-1:0]            tlast;
  logic [N-1:0]            tuser;
  logic [ID_WIDTH-1:0]     tid;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, tid, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, tid, output tready);
endinterface

// File: rtl/eth_axis_tx_arbiter.sv
// eth_axis_tx_arbiter
// Round-robin, frame-atomic merge of S_COUNT AXI-stream sources into one stream
// toward the MAC TX FIFO. Frames longer than MAX_FRAME_BEATS are cut: the last
// forwarded beat is marked tlast+tuser and the remainder is absorbed.
// Ports:
//   clk            - sole clock, rising edge
//   rst_n          - synchronous active-low reset
//   s_axis (slave) - S_COUNT source lanes (tid unused on this side)
//   m_axis (master)- merged output, single register stage, tid = source port
//   stat_frame     - one-cycle pulse per frame completed on the output
//   stat_oversize  - one-cycle pulse per truncated frame
//   stat_port      - port index qualifying either pulse
module eth_axis_tx_arbiter #(
  parameter int S_COUNT         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_FRAME_BEATS = 1518,
  localparam int ID_WIDTH       = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_axis_tx_arbiter_if.slave  s_axis,
  eth_axis_tx_arbiter_if.master m_axis,
  output logic                  stat_frame,
  output logic                  stat_oversize,
  output logic [ID_WIDTH-1:0]   stat_port
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [15:0]         LAST_CNT = 16'(MAX_FRAME_BEATS - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(S_COUNT - 1);

  state_t                state_r, state_s;
  logic [ID_WIDTH-1:0]   grant_r, rr_ptr_r, sel_s;
  logic [15:0]           count_r;
  logic                  any_valid_s;

  logic [DATA_WIDTH-1:0] in_data_s;
  logic [KEEP_WIDTH-1:0] in_keep_s;
  logic                  in_valid_s, in_last_s, in_user_s;

  logic                  out_ready_s, port_ready_s, accept_s, trunc_s;
  logic [S_COUNT-1:0]    s_ready_s;

  logic [DATA_WIDTH-1:0] m_tdata_r;
  logic [KEEP_WIDTH-1:0] m_tkeep_r;
  logic                  m_tvalid_r, m_tlast_r, m_tuser_r;
  logic [ID_WIDTH-1:0]   m_tid_r;
  logic                  stat_frame_r, stat_oversize_r;
  logic [ID_WIDTH-1:0]   stat_port_r;

  // Round-robin pick: lowest offset from rr_ptr whose tvalid is set wins.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    any_valid_s = |s_axis.tvalid;
    sel_s       = rr_ptr_r;
    for (int k = S_COUNT - 1; k >= 0; k--) begin
      idx_v = int'(rr_ptr_r) + k;
      if (idx_v >= S_COUNT) begin
        idx_v = idx_v - S_COUNT;
      end else begin
        idx_v = idx_v;
      end
      if (s_axis.tvalid[idx_v[ID_WIDTH-1:0]]) begin
        sel_s = idx_v[ID_WIDTH-1:0];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Mux out the beat presented by the currently granted port.
  always_comb begin
    in_data_s  = {DATA_WIDTH{1'b0}};
    in_keep_s  = {KEEP_WIDTH{1'b0}};
    in_valid_s = 1'b0;
    in_last_s  = 1'b0;
    in_user_s  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_r == ID_WIDTH'(i)) begin
        in_data_s  = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_keep_s  = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        in_valid_s = s_axis.tvalid[i];
        in_last_s  = s_axis.tlast[i];
        in_user_s  = s_axis.tuser[i];
      end else begin
        in_data_s  = in_data_s;
      end
    end
  end

  // Next-state and handshake decode. The grant cycle never accepts a beat,
  // which gives the one idle cycle between frames.
  always_comb begin
    state_s      = state_r;
    out_ready_s  = !m_tvalid_r || m_axis.tready;
    port_ready_s = 1'b0;
    trunc_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_s = ST_PASS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PASS: begin
        port_ready_s = out_ready_s;
        if (out_ready_s && in_valid_s && in_last_s) begin
          state_s = ST_IDLE;
        end else if (out_ready_s && in_valid_s && (count_r == LAST_CNT)) begin
          state_s = ST_DROP;
          trunc_s = 1'b1;
        end else begin
          state_s = ST_PASS;
        end
      end
      ST_DROP: begin
        port_ready_s = 1'b1;
        if (in_valid_s && in_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    accept_s = port_ready_s && in_valid_s;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_r == ID_WIDTH'(i)) begin
        s_ready_s[i] = port_ready_s;
      end else begin
        s_ready_s[i] = 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant, round-robin pointer, beat counter, output register and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_r         <= {ID_WIDTH{1'b0}};
      rr_ptr_r        <= {ID_WIDTH{1'b0}};
      count_r         <= 16'd0;
      m_tdata_r       <= {DATA_WIDTH{1'b0}};
      m_tkeep_r       <= {KEEP_WIDTH{1'b0}};
      m_tvalid_r      <= 1'b0;
      m_tlast_r       <= 1'b0;
      m_tuser_r       <= 1'b0;
      m_tid_r         <= {ID_WIDTH{1'b0}};
      stat_frame_r    <= 1'b0;
      stat_oversize_r <= 1'b0;
      stat_port_r     <= {ID_WIDTH{1'b0}};
    end else begin
      stat_frame_r    <= 1'b0;
      stat_oversize_r <= 1'b0;
      if (state_r == ST_IDLE && any_valid_s) begin
        grant_r  <= sel_s;
        rr_ptr_r <= (sel_s == LAST_ID) ? {ID_WIDTH{1'b0}} : sel_s + ID_WIDTH'(1);
        count_r  <= 16'd0;
      end
      // Load wins over drain: a new beat is only accepted when the slot frees.
      if (state_r == ST_PASS && accept_s) begin
        m_tdata_r  <= in_data_s;
        m_tkeep_r  <= in_keep_s;
        m_tvalid_r <= 1'b1;
        m_tlast_r  <= in_last_s || trunc_s;
        m_tuser_r  <= in_user_s || trunc_s;
        m_tid_r    <= grant_r;
        count_r    <= count_r + 16'd1;
        if (in_last_s || trunc_s) begin
          stat_frame_r    <= 1'b1;
          stat_oversize_r <= trunc_s;
          stat_port_r     <= grant_r;
        end
      end else if (m_tvalid_r && m_axis.tready) begin
        m_tvalid_r <= 1'b0;
      end
    end
  end

  assign s_axis.tready  = s_ready_s;
  assign m_axis.tdata   = m_tdata_r;
  assign m_axis.tkeep   = m_tkeep_r;
  assign m_axis.tvalid  = m_tvalid_r;
  assign m_axis.tlast   = m_tlast_r;
  assign m_axis.tuser   = m_tuser_r;
  assign m_axis.tid     = m_tid_r;
  assign stat_frame     = stat_frame_r;
  assign stat_oversize  = stat_oversize_r;
  assign stat_port      = stat_port_r;

endmodule

// File: tb/tb_eth_axis_tx_arbiter.sv
// tb_eth_axis_tx_arbiter
// Directed bench for eth_axis_tx_arbiter with S_COUNT=4, DATA_WIDTH=8,
// MAX_FRAME_BEATS=8. Per-port source queues feed the DUT; a monitor collects
// output beats and stat pulses, which are compared with hand-derived values.
module tb_eth_axis_tx_arbiter;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic        u;
    logic [1:0]  id;
    logic [31:0] cyc;
  } out_t;

  logic          clk;
  logic          rst_n;
  logic          stat_frame;
  logic          stat_oversize;
  logic [IW-1:0] stat_port;

  eth_axis_tx_arbiter_if #(.N(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) s_if ();
  eth_axis_tx_arbiter_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) m_if ();

  eth_axis_tx_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_FRAME_BEATS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
    .stat_frame(stat_frame), .stat_oversize(stat_oversize), .stat_port(stat_port)
  );

  beat_t       srcq[S][$];
  out_t        outq[$];
  int          frame_ports[$];
  int          acc_cnt[S];
  logic [3:0]  fire;
  int          frames, oversize, ovs_port;
  int          tests_run, tests_failed;
  int          cyc;
  logic        rnd_ready, stall_prev;
  logic [12:0] snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_frame(input int port, input int n, input logic [7:0] base, input logic user0);
    for (int k = 0; k < n; k++) begin
      srcq[port].push_back('{d: base + 8'(k), l: (k == n - 1), u: (k == 0) && user0});
    end
  endtask

  task automatic clear_mon();
    outq.delete();
    frame_ports.delete();
    frames   = 0;
    oversize = 0;
    ovs_port = 0;
    for (int i = 0; i < S; i++) acc_cnt[i] = 0;
  endtask

  // One clock: retire accepted beats and drive after the edge, observe at negedge.
  task automatic step();
    logic [12:0] cur;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        s_if.tvalid[i]         = 1'b1;
        s_if.tdata[i*DW +: DW] = srcq[i][0].d;
        s_if.tlast[i]          = srcq[i][0].l;
        s_if.tuser[i]          = srcq[i][0].u;
      end else begin
        s_if.tvalid[i]         = 1'b0;
        s_if.tdata[i*DW +: DW] = 8'h00;
        s_if.tlast[i]          = 1'b0;
        s_if.tuser[i]          = 1'b0;
      end
    end
    m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc++;
    @(negedge clk);
    for (int i = 0; i < S; i++) begin
      fire[i] = s_if.tvalid[i] && s_if.tready[i];
      if (fire[i]) acc_cnt[i]++;
    end
    cur = {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, m_if.tid};
    if (stall_prev && rst_n) check_eq("hold", 32'(cur), 32'(snap));
    stall_prev = rst_n && m_if.tvalid[0] && !m_if.tready[0];
    snap       = cur;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      outq.push_back('{d: m_if.tdata, l: m_if.tlast[0], u: m_if.tuser[0], id: m_if.tid, cyc: 32'(cyc)});
    end
    if (stat_frame) begin
      frames++;
      frame_ports.push_back(int'(stat_port));
    end
    if (stat_oversize) begin
      oversize++;
      ovs_port = int'(stat_port);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int  n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = m_if.tvalid[0];
      for (int i = 0; i < S; i++) if (srcq[i].size() > 0) busy = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(n < budget), 32'd1);
    repeat (3) step();
  endtask

  task automatic check_out(input string tag, input int k, input logic [7:0] d,
                           input logic l, input logic u, input logic [1:0] id);
    if (k < outq.size()) begin
      check_eq($sformatf("%s_d%0d", tag, k), 32'(outq[k].d), 32'(d));
      check_eq($sformatf("%s_l%0d", tag, k), 32'(outq[k].l), 32'(l));
      check_eq($sformatf("%s_u%0d", tag, k), 32'(outq[k].u), 32'(u));
      check_eq($sformatf("%s_id%0d", tag, k), 32'(outq[k].id), 32'(id));
    end else begin
      check_eq($sformatf("%s_missing%0d", tag, k), 32'(outq.size()), 32'(k + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tvalid"}, 32'(m_if.tvalid), 32'd0);
    check_eq({tag, "_tdata"}, 32'(m_if.tdata), 32'd0);
    check_eq({tag, "_tlast"}, 32'(m_if.tlast), 32'd0);
    check_eq({tag, "_tuser"}, 32'(m_if.tuser), 32'd0);
    check_eq({tag, "_tid"}, 32'(m_if.tid), 32'd0);
    check_eq({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
    check_eq({tag, "_stat_frame"}, 32'(stat_frame), 32'd0);
    check_eq({tag, "_stat_oversize"}, 32'(stat_oversize), 32'd0);
    check_eq({tag, "_stat_port"}, 32'(stat_port), 32'd0);
  endtask

  task automatic reset_dut(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < S; i++) srcq[i].delete();
    fire = 4'b0000;
    repeat (cycles) step();
    rst_n = 1'b1;
    clear_mon();
  endtask

  initial begin
    int nlast;
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rnd_ready    = 1'b0;
    stall_prev   = 1'b0;
    snap         = 13'd0;
    fire         = 4'b0000;
    rst_n        = 1'b0;
    s_if.tdata   = 32'd0;
    s_if.tkeep   = 4'b1111;
    s_if.tvalid  = 4'b0000;
    s_if.tlast   = 4'b0000;
    s_if.tuser   = 4'b0000;
    s_if.tid     = 2'd0;
    m_if.tready  = 1'b1;
    clear_mon();

    // Reset with a source already valid: everything must stay quiet.
    push_frame(1, 2, 8'hEE, 1'b0);
    repeat (3) step();
    check_idle_outputs("rst");
    reset_dut(1);

    // Ports 0 and 2 together: port 0 first, one idle cycle, then port 2.
    push_frame(0, 3, 8'h01, 1'b0);
    push_frame(2, 3, 8'h21, 1'b0);
    drain("t1", 60);
    check_eq("t1_count", 32'(outq.size()), 32'd6);
    for (int k = 0; k < 3; k++) check_out("t1a", k, 8'h01 + 8'(k), (k == 2), 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) check_out("t1b", k + 3, 8'h21 + 8'(k), (k == 2), 1'b0, 2'd2);
    if (outq.size() == 6) begin
      check_eq("t1_rate", outq[1].cyc - outq[0].cyc, 32'd1);
      check_eq("t1_gap", outq[3].cyc - outq[2].cyc, 32'd2);
    end
    check_eq("t1_frames", 32'(frames), 32'd2);
    if (frame_ports.size() == 2) begin
      check_eq("t1_fport0", 32'(frame_ports[0]), 32'd0);
      check_eq("t1_fport1", 32'(frame_ports[1]), 32'd2);
    end

    // All ports valid with 1-beat frames: strict rotation, 2 cycles per beat.
    reset_dut(2);
    for (int p = 0; p < S; p++) begin
      push_frame(p, 1, 8'h10 * 8'(p + 1), 1'b0);
      push_frame(p, 1, 8'h10 * 8'(p + 1) + 8'h01, 1'b0);
    end
    drain("t2", 80);
    for (int k = 0; k < 8; k++) begin
      check_out("t2", k, 8'h10 * 8'((k % 4) + 1) + 8'(k / 4), 1'b1, 1'b0, 2'(k % 4));
    end
    for (int k = 1; k < 8; k++) begin
      if (k < outq.size()) check_eq($sformatf("t2_gap%0d", k), outq[k].cyc - outq[k-1].cyc, 32'd2);
    end
    check_eq("t2_frames", 32'(frames), 32'd8);

    // Oversize: 12-beat frame on port 1 cut after 8 beats, tail absorbed.
    clear_mon();
    push_frame(1, 12, 8'h50, 1'b0);
    drain("t3", 80);
    check_eq("t3_count", 32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++) check_out("t3", k, 8'h50 + 8'(k), (k == 7), (k == 7), 2'd1);
    check_eq("t3_oversize", 32'(oversize), 32'd1);
    check_eq("t3_ovs_port", 32'(ovs_port), 32'd1);
    check_eq("t3_frames", 32'(frames), 32'd1);
    check_eq("t3_absorbed", 32'(acc_cnt[1]), 32'd12);

    // Exactly MAX beats with tlast on the last one: not truncated.
    clear_mon();
    push_frame(1, 8, 8'h60, 1'b0);
    drain("t4", 80);
    check_eq("t4_count", 32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++) check_out("t4", k, 8'h60 + 8'(k), (k == 7), 1'b0, 2'd1);
    check_eq("t4_oversize", 32'(oversize), 32'd0);
    check_eq("t4_frames", 32'(frames), 32'd1);

    // Input tuser passes through per beat.
    clear_mon();
    push_frame(0, 2, 8'h70, 1'b1);
    drain("t5", 40);
    check_out("t5", 0, 8'h70, 1'b0, 1'b1, 2'd0);
    check_out("t5", 1, 8'h71, 1'b1, 1'b0, 2'd0);

    // Random output backpressure over 64 beats from port 3.
    clear_mon();
    rnd_ready = 1'b1;
    for (int f = 0; f < 8; f++) push_frame(3, 8, 8'h80 + 8'(f * 8), 1'b0);
    drain("t6", 2000);
    rnd_ready = 1'b0;
    check_eq("t6_count", 32'(outq.size()), 32'd64);
    for (int k = 0; k < 64; k++) check_out("t6", k, 8'h80 + 8'(k), ((k % 8) == 7), 1'b0, 2'd3);
    check_eq("t6_frames", 32'(frames), 32'd8);

    // Reset at beat 5 of a 10-beat frame, then port 0 must win over port 3.
    clear_mon();
    push_frame(2, 10, 8'hA0, 1'b0);
    for (int n = 0; n < 40 && outq.size() < 5; n++) step();
    check_eq("t7_reached", 32'(outq.size()), 32'd5);
    rst_n = 1'b0;
    srcq[2].delete();
    fire = 4'b0000;
    step();
    check_idle_outputs("t7_rst");
    rst_n = 1'b1;
    nlast = 0;
    foreach (outq[k]) if (outq[k].l) nlast++;
    check_eq("t7_nolast", 32'(nlast), 32'd0);
    check_eq("t7_noframe", 32'(frames), 32'd0);
    clear_mon();
    push_frame(3, 2, 8'hC1, 1'b0);
    push_frame(0, 3, 8'hB1, 1'b0);
    drain("t7", 60);
    check_eq("t7_count", 32'(outq.size()), 32'd5);
    for (int k = 0; k < 3; k++) check_out("t7a", k, 8'hB1 + 8'(k), (k == 2), 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) check_out("t7b", k + 3, 8'hC1 + 8'(k), (k == 1), 1'b0, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
